inst_fetch_unit: RTL
====================

# inst_fetch_unit

Fetch-side consumer of the program counter. Owns the fetch PC, issues sequential instruction requests on the SRAM-like instruction bus, matches in-order responses to their PCs, and buffers {pc, inst} pairs in a small FIFO for decode. On redirect (branch/exception), it flushes buffered work and discards stale in-flight responses.

## Interface
- `START_PC`, 32'hBFC0_0000: fetch PC after reset.
- `DEPTH`, 4: FIFO entries; also the cap on outstanding plus buffered work. Power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `redirect_valid` in 1: restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new fetch address.
- `inst_req` out 1: request valid.
- `inst_addr` out 32: request address.
- `inst_addr_ok` in 1: request accepted this cycle.
- `inst_data_ok` in 1: response returned this cycle. Responses arrive in request order.
- `inst_rdata` in 32: response data.
- `out_valid` out 1: FIFO head valid.
- `out_pc` out 32: PC of head.
- `out_inst` out 32: instruction of head (0 when `out_adel`).
- `out_adel` out 1: head is a misaligned-fetch entry.
- `out_ready` in 1: decode accepts head.

## Operation
- Reset values: `fetch_pc` = START_PC, `inst_req` = 0, `out_valid` = 0, `out_pc`/`out_inst` = 0, `out_adel` = 0, `outstanding` = 0, `discard` = 0, FIFO empty, `halt` = 0.
- Credit: `credit = (outstanding + fifo_count) < DEPTH`.
- Request: `inst_req = !rst && !halt && !redirect_valid && credit && fetch_pc[1:0]==0`. `inst_addr = fetch_pc` at all times.
- An address is committed only in a cycle with `inst_req && inst_addr_ok`. Before that, the request may be withdrawn or retargeted.
- Accept (`inst_req && inst_addr_ok`):
  - push `fetch_pc` into the pending-PC queue (DEPTH entries);
  - `fetch_pc += 4` (32-bit wrap, 0xFFFF_FFFC → 0);
  - `outstanding++`.
- Response (`inst_data_ok`):
  - pop the pending-PC queue and decrement `outstanding`;
  - if `discard > 0`, drop the response and decrement `discard`;
  - otherwise push {pc, `inst_rdata`, 0} into the FIFO.
  - Accept and response in the same cycle: `outstanding` is unchanged.
- Misaligned PC (`fetch_pc[1:0] != 0`, `!halt`, FIFO not full): no bus request is issued.
  - Push {fetch_pc, 0, 1} into the FIFO and set `halt`.
  - Only a redirect clears `halt`.
- Redirect (priority over everything else in that cycle):
  - `fetch_pc <= redirect_pc` and `halt <= 0`;
  - FIFO is flushed;
  - `discard <= outstanding_next`, i.e. after this cycle's accept and response. An accept in the redirect cycle counts as stale, but `inst_req` is 0 then, so this cannot occur.
  - A response in the redirect cycle is dropped.
  - `out_valid` is forced to 0, so no pop occurs.
  - The pending-PC queue is not flushed; stale entries drain through `discard`.
- Output: `out_valid = !fifo_empty && !redirect_valid`. Pop on `out_valid && out_ready`.
- Push and pop in the same cycle are legal. The credit rule guarantees a push never meets a full FIFO.

## Timing
- First request: `inst_req` = 1 with `inst_addr` = START_PC in the first cycle after `rst` deasserts.
- Back-to-back: one accept per cycle while `inst_addr_ok` = 1 and credit holds.
- Response latency: `inst_data_ok` in cycle N gives `out_valid` = 1 with that entry in N+1 (registered FIFO), if the FIFO was otherwise empty.
- Redirect latency: `redirect_valid` in cycle N gives `inst_req` = 1 with `inst_addr` = `redirect_pc` in N+1.
- Misaligned entry: becomes visible one cycle after it is detected.
- Asynchronous `rst` mid-operation returns all state to reset values immediately. A bus response still in flight after reset is the bus's responsibility and is not tracked.

## Structure
- Shared defines header holds START_PC, the instruction width, and the FIFO entry layout {pc[31:0], inst[31:0], adel}.
- One sub-module, `fetch_fifo`: synchronous FIFO with parameters DEPTH and WIDTH, ports push, pop, flush, count, empty, full. Flush takes priority over push.
- The pending-PC queue may reuse `fetch_fifo` (WIDTH = 32, flush tied 0).

## Test plan
- Reset then streaming (`addr_ok` = `data_ok` = 1 with 1-cycle lag, `out_ready` = 1): addresses BFC00000, BFC00004, BFC00008… in order; `out_pc`/`out_inst` pair correctly; one output per cycle.
- Back-pressure (`out_ready` = 0): exactly 4 accepts, then `inst_req` = 0. Raising `out_ready` resumes requests one cycle after the first pop.
- Redirect with 2 outstanding and 1 buffered: FIFO empties, both late responses are dropped, and the next `out_pc` is `redirect_pc` (e.g. 80000180).
- Redirect in the same cycle as `inst_data_ok`: that response is dropped; `discard` equals the remaining outstanding count.
- Redirect to 80000002: no `inst_req`; one entry with `out_adel` = 1 and `out_pc` = 80000002; stays halted until the next redirect.
- Assert `rst` with 3 outstanding: all outputs return to reset values in the same cycle, and fetch restarts at START_PC after deassertion.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The FIFO entry layout is {pc, inst, adel}.
package inst_fetch_unit_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INST_W = 32;
    localparam logic [XLEN-1:0] START_PC_DEFAULT = 32'hBFC0_0000;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              adel;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_t;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction bus, redirect and decode-side handshake of the fetch unit.
// The master modport is the fetch unit; the slave modport is its environment.
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;

    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              inst_req;
    logic [XLEN-1:0]   inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [INST_W-1:0] inst_rdata;
    logic              out_valid;
    logic [XLEN-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              out_adel;
    logic              out_ready;

    modport master (
        input  redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
        output inst_req, inst_addr, out_valid, out_pc, out_inst, out_adel
    );

    modport slave (
        output redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, out_ready,
        input  inst_req, inst_addr, out_valid, out_pc, out_inst, out_adel
    );

endinterface

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Synchronous power-of-two FIFO with combinational head read.
// Flush takes priority over push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch unit: owns the fetch PC, issues sequential requests, pairs in-order
// responses with their PCs and buffers {pc, inst, adel} entries for decode.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] START_PC = START_PC_DEFAULT,
    parameter int unsigned DEPTH    = 4
) (
    input logic              clk,
    input logic              rst,
    inst_fetch_unit_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   discard;
    logic [XLEN-1:0] pend_pc;
    logic            pend_empty;
    logic            pend_full;
    logic            fifo_empty;
    logic            fifo_full;
    logic            credit;
    logic            accept;
    logic            resp;
    logic            resp_keep;
    logic            mis_push;
    logic            fifo_push;
    logic            fifo_pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic [ENTRY_W-1:0] fifo_rdata;

    assign credit = !pend_full &&
                    (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(DEPTH));

    assign bus.inst_req  = !rst && (state == ST_FETCH) && !bus.redirect_valid &&
                           credit && is_aligned(fetch_pc);
    assign bus.inst_addr = fetch_pc;

    assign accept    = bus.inst_req && bus.inst_addr_ok;
    assign resp      = bus.inst_data_ok && !pend_empty;
    // Responses owed to a pre-redirect stream are dropped until discard drains.
    assign resp_keep = resp && !bus.redirect_valid && (discard == '0);
    assign outstanding_next = outstanding + CW'(accept) - CW'(resp);

    // Halt FSM: a misaligned PC emits one adel entry and parks until redirect.
    always_comb begin
        state_next = state;
        mis_push   = 1'b0;
        case (state)
            ST_FETCH: begin
                if (!bus.redirect_valid && !is_aligned(fetch_pc) && !fifo_full) begin
                    mis_push   = 1'b1;
                    state_next = ST_HALT;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
        if (bus.redirect_valid) state_next = ST_FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= START_PC;
            discard  <= '0;
        end else begin
            if (bus.redirect_valid) fetch_pc <= bus.redirect_pc;
            else if (accept)        fetch_pc <= fetch_pc + 32'd4;

            if (bus.redirect_valid)        discard <= outstanding_next;
            else if (resp && discard != '0) discard <= discard - CW'(1);
        end
    end

    always_comb begin
        push_entry = '0;
        if (resp_keep) begin
            push_entry.pc   = pend_pc;
            push_entry.inst = bus.inst_rdata;
            push_entry.adel = 1'b0;
        end else begin
            push_entry.pc   = fetch_pc;
            push_entry.inst = '0;
            push_entry.adel = 1'b1;
        end
    end

    assign fifo_push = resp_keep || mis_push;
    assign fifo_pop  = bus.out_valid && bus.out_ready;

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pend (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (resp),
        .flush (1'b0),
        .wdata (fetch_pc),
        .rdata (pend_pc),
        .count (outstanding),
        .empty (pend_empty),
        .full  (pend_full)
    );

    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_out (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (bus.redirect_valid),
        .wdata (push_entry),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Head fields read as zero whenever the buffer is empty.
    assign head          = fifo_empty ? fetch_entry_t'('0) : fetch_entry_t'(fifo_rdata);
    assign bus.out_valid = !fifo_empty && !bus.redirect_valid;
    assign bus.out_pc    = head.pc;
    assign bus.out_inst  = head.inst;
    assign bus.out_adel  = head.adel;

endmodule
